// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the two-port SRAM arbiter.
package mem_arb_pkg;

   localparam int WAIT_STATES_MAX = 15;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   typedef enum logic {PORT_CPU, PORT_DBG} port_id_t;

   function automatic port_id_t other_port(input port_id_t id);
      return (id == PORT_CPU) ? PORT_DBG : PORT_CPU;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle for one requester of the SRAM arbiter.
interface mem_arbiter_if;

   logic        req;
   logic        we;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        ack;

   modport master (output req, we, addr, wdata, input rdata, ack);
   modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between the CPU and debug requesters.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic     cpu_req,
   input  logic     dbg_req,
   input  port_id_t prio,
   output port_id_t grant_id,
   output logic     grant_valid
);

   // Only a tie consults the priority pointer; a lone request always wins.
   always_comb begin
      grant_valid = cpu_req | dbg_req;
      if (cpu_req && dbg_req) begin
         grant_id = prio;
      end else if (dbg_req) begin
         grant_id = PORT_DBG;
      end else begin
         grant_id = PORT_CPU;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU + debug) arbiter in front of an asynchronous SRAM.
// Define MEM_ARB_RR_EN for round-robin ties; otherwise the CPU always wins.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WAIT_STATES = 2
)
(
   input  logic        Clk,
   input  logic        Reset,
   mem_arbiter_if.slave cpu,
   mem_arbiter_if.slave dbg,
   output logic [15:0] sram_addr,
   output logic [15:0] sram_dout,
   output logic        sram_dout_en,
   input  logic [15:0] sram_din,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n
);

   localparam int CW = $clog2(WAIT_STATES_MAX + 1);
   localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_STATES - 1);

   state_t        state;
   state_t        next_state;
   logic [CW-1:0] wait_cnt;
   port_id_t      cur_id;
   logic          cur_we;
   port_id_t      prio;
   port_id_t      grant_id;
   logic          grant_valid;
   logic [15:0]   cpu_rdata_q;
   logic [15:0]   dbg_rdata_q;
   logic          ack_cpu;
   logic          ack_dbg;

   mem_arb_pick u_pick (
      .cpu_req     (cpu.req),
      .dbg_req     (dbg.req),
      .prio        (prio),
      .grant_id    (grant_id),
      .grant_valid (grant_valid)
   );

`ifdef MEM_ARB_RR_EN
   // The port just served loses the next tie.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         prio <= PORT_CPU;
      end else if (state == DONE) begin
         prio <= other_port(cur_id);
      end
   end
`else
   assign prio = PORT_CPU;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // The SRAM bus is driven only from values latched in IDLE, so requesters may change inputs mid-transfer.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cur_id    <= PORT_CPU;
         cur_we    <= 1'b0;
         sram_addr <= 16'h0000;
         sram_dout <= 16'h0000;
         wait_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  cur_id <= grant_id;
                  if (grant_id == PORT_DBG) begin
                     cur_we    <= dbg.we;
                     sram_addr <= dbg.addr;
                     sram_dout <= dbg.wdata;
                  end else begin
                     cur_we    <= cpu.we;
                     sram_addr <= cpu.addr;
                     sram_dout <= cpu.wdata;
                  end
               end
            end
            SETUP:   wait_cnt <= WAIT_LOAD;
            ACCESS:  if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         cpu_rdata_q <= 16'h0000;
         dbg_rdata_q <= 16'h0000;
      end else if (state == ACCESS && wait_cnt == '0 && !cur_we) begin
         if (cur_id == PORT_CPU) begin
            cpu_rdata_q <= sram_din;
         end else begin
            dbg_rdata_q <= sram_din;
         end
      end
   end

   always_comb begin
      next_state   = state;
      sram_ce_n    = 1'b1;
      sram_oe_n    = 1'b1;
      sram_we_n    = 1'b1;
      sram_dout_en = 1'b0;
      ack_cpu      = 1'b0;
      ack_dbg      = 1'b0;
      case (state)
         IDLE: begin
            if (grant_valid) next_state = SETUP;
         end
         SETUP: begin
            sram_ce_n    = 1'b0;
            sram_dout_en = cur_we;
            next_state   = ACCESS;
         end
         ACCESS: begin
            sram_ce_n    = 1'b0;
            sram_oe_n    = cur_we;
            sram_we_n    = ~cur_we;
            sram_dout_en = cur_we;
            if (wait_cnt == '0) next_state = DONE;
         end
         DONE: begin
            ack_cpu    = (cur_id == PORT_CPU);
            ack_dbg    = (cur_id == PORT_DBG);
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign cpu.ack   = ack_cpu;
   assign dbg.ack   = ack_dbg;
   assign cpu.rdata = cpu_rdata_q;
   assign dbg.rdata = dbg_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level timing and memory model.
module tb_mem_arbiter;

   localparam int WS = 2;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   always #5 Clk = ~Clk;

   mem_arbiter_if cpu_if ();
   mem_arbiter_if dbg_if ();

   logic [15:0] sram_addr, sram_dout, sram_din;
   logic        sram_dout_en, sram_ce_n, sram_oe_n, sram_we_n;
   logic [15:0] sram_mem [0:65535];
   logic [15:0] ref_mem  [0:65535];

   logic        req_v   [2];
   logic        we_v    [2];
   logic [15:0] addr_v  [2];
   logic [15:0] wdata_v [2];

   assign cpu_if.req   = req_v[0];
   assign cpu_if.we    = we_v[0];
   assign cpu_if.addr  = addr_v[0];
   assign cpu_if.wdata = wdata_v[0];
   assign dbg_if.req   = req_v[1];
   assign dbg_if.we    = we_v[1];
   assign dbg_if.addr  = addr_v[1];
   assign dbg_if.wdata = wdata_v[1];

   mem_arbiter #(.WAIT_STATES(WS)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .cpu          (cpu_if),
      .dbg          (dbg_if),
      .sram_addr    (sram_addr),
      .sram_dout    (sram_dout),
      .sram_dout_en (sram_dout_en),
      .sram_din     (sram_din),
      .sram_ce_n    (sram_ce_n),
      .sram_oe_n    (sram_oe_n),
      .sram_we_n    (sram_we_n)
   );

   // Behavioural asynchronous SRAM
   assign sram_din = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'hDEAD;
   always @(posedge Clk) begin
      if (!sram_ce_n && !sram_we_n && sram_dout_en) sram_mem[sram_addr] <= sram_dout;
   end

   // Extra instances for the extreme wait-state settings
   mem_arbiter_if c1_if (), d1_if (), c15_if (), d15_if ();
   logic        lsel = 1'b0, lreq = 1'b0;
   logic [15:0] l1_addr, l1_dout, l1_din, l15_addr, l15_dout, l15_din;
   logic        l1_den, l1_ce_n, l1_oe_n, l1_we_n, l15_den, l15_ce_n, l15_oe_n, l15_we_n;

   assign c1_if.req    = lreq & ~lsel;
   assign c1_if.we     = 1'b0;
   assign c1_if.addr   = 16'h0077;
   assign c1_if.wdata  = 16'h0000;
   assign d1_if.req    = 1'b0;
   assign d1_if.we     = 1'b0;
   assign d1_if.addr   = 16'h0000;
   assign d1_if.wdata  = 16'h0000;
   assign c15_if.req   = lreq & lsel;
   assign c15_if.we    = 1'b0;
   assign c15_if.addr  = 16'h0077;
   assign c15_if.wdata = 16'h0000;
   assign d15_if.req   = 1'b0;
   assign d15_if.we    = 1'b0;
   assign d15_if.addr  = 16'h0000;
   assign d15_if.wdata = 16'h0000;
   assign l1_din  = !l1_oe_n  ? 16'h5A77 : 16'hDEAD;
   assign l15_din = !l15_oe_n ? 16'h5A77 : 16'hDEAD;

   mem_arbiter #(.WAIT_STATES(1)) dut1 (
      .Clk(Clk), .Reset(Reset), .cpu(c1_if), .dbg(d1_if),
      .sram_addr(l1_addr), .sram_dout(l1_dout), .sram_dout_en(l1_den), .sram_din(l1_din),
      .sram_ce_n(l1_ce_n), .sram_oe_n(l1_oe_n), .sram_we_n(l1_we_n)
   );

   mem_arbiter #(.WAIT_STATES(15)) dut15 (
      .Clk(Clk), .Reset(Reset), .cpu(c15_if), .dbg(d15_if),
      .sram_addr(l15_addr), .sram_dout(l15_dout), .sram_dout_en(l15_den), .sram_din(l15_din),
      .sram_ce_n(l15_ce_n), .sram_oe_n(l15_oe_n), .sram_we_n(l15_we_n)
   );

   // Reference model state: one transfer in flight, timed from the cycle its request was sampled
   int          k = 0;
   bit          busy = 1'b0;
   int          start = 0;
   int          t_port = 0;
   bit          t_we = 1'b0;
   logic [15:0] t_addr = 16'h0000, t_wdata = 16'h0000;
   int          free_at = 0;
   int          ptr = 0;
   logic [15:0] last_addr = 16'h0000, last_dout = 16'h0000;
   logic [15:0] exp_rdata [2];
   bit          pending   [2];
   bit          completed [2];
   int          checks = 0;
   int          errors = 0;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %h, want %h", tag, k, actual, expected);
      end
   endtask

   task automatic issueRequest(input int p, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
      req_v[p]   = 1'b1;
      we_v[p]    = we;
      addr_v[p]  = addr;
      wdata_v[p] = wdata;
      pending[p] = 1'b1;
   endtask

   // Wait for the falling edge and compare every DUT output with the model's prediction
   task automatic sampleCycle();
      int          phase;
      logic        ce, oe, we, den;
      logic        a [2];
      logic [15:0] ea, ed;
      @(negedge Clk);
      k++;
      ce = 1'b1; oe = 1'b1; we = 1'b1; den = 1'b0;
      a[0] = 1'b0; a[1] = 1'b0;
      ea = last_addr; ed = last_dout;
      if (busy) begin
         phase = k - start;
         if (phase >= 1 && phase <= WS + 1) begin
            ce = 1'b0; den = t_we; ea = t_addr; ed = t_wdata;
         end
         if (phase >= 2 && phase <= WS + 1) begin
            if (t_we) we = 1'b0;
            else      oe = 1'b0;
         end
         if (phase >= WS + 2) begin
            a[t_port] = 1'b1; ea = t_addr; ed = t_wdata;
            if (t_we) ref_mem[t_addr] = t_wdata;
            else      exp_rdata[t_port] = ref_mem[t_addr];
            last_addr = t_addr; last_dout = t_wdata;
            busy = 1'b0; free_at = k + 1; completed[t_port] = 1'b1;
         end
      end
      checkOutput("ce_n", 32'(sram_ce_n), 32'(ce));
      checkOutput("oe_n", 32'(sram_oe_n), 32'(oe));
      checkOutput("we_n", 32'(sram_we_n), 32'(we));
      checkOutput("dout_en", 32'(sram_dout_en), 32'(den));
      checkOutput("oe_we_overlap", 32'(!sram_oe_n && !sram_we_n), 32'd0);
      checkOutput("cpu_ack", 32'(cpu_if.ack), 32'(a[0]));
      checkOutput("dbg_ack", 32'(dbg_if.ack), 32'(a[1]));
      checkOutput("sram_addr", 32'(sram_addr), 32'(ea));
      checkOutput("sram_dout", 32'(sram_dout), 32'(ed));
      checkOutput("cpu_rdata", 32'(cpu_if.rdata), 32'(exp_rdata[0]));
      checkOutput("dbg_rdata", 32'(dbg_if.rdata), 32'(exp_rdata[1]));
   endtask

   // mode 0: directed only, 1: random requesters, 2: both ports keep requesting
   task automatic applyStimulus(input int mode, input bit rst);
      Reset = rst;
      for (int p = 0; p < 2; p++) begin
         if (completed[p] || rst) begin
            req_v[p] = 1'b0; pending[p] = 1'b0; completed[p] = 1'b0;
         end
      end
      if (rst) begin
         // An aborted write that already pulsed WE has reached the SRAM array
         if (busy && t_we && (k - start) >= 2) ref_mem[t_addr] = t_wdata;
         busy = 1'b0; free_at = k + 1; ptr = 0;
         last_addr = 16'h0000; last_dout = 16'h0000;
         exp_rdata[0] = 16'h0000; exp_rdata[1] = 16'h0000;
         return;
      end
      for (int p = 0; p < 2; p++) begin
         if (!pending[p] && ((mode == 1 && $urandom_range(0, 3) == 0) || mode == 2)) begin
            issueRequest(p, (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0,
                         ($urandom_range(0, 7) == 0) ? 16'($urandom) : {12'h000, 4'($urandom)},
                         16'($urandom));
         end
      end
      if (mode == 1 && busy) begin
         addr_v[t_port]  = 16'($urandom);
         wdata_v[t_port] = 16'($urandom);
      end
      if (!busy && k >= free_at && (req_v[0] || req_v[1])) begin
         if (req_v[0] && req_v[1]) t_port = ptr;
         else                      t_port = req_v[0] ? 0 : 1;
         t_we = we_v[t_port]; t_addr = addr_v[t_port]; t_wdata = wdata_v[t_port];
         busy = 1'b1; start = k;
`ifdef MEM_ARB_RR_EN
         ptr = 1 - t_port;
`endif
      end
   endtask

   task automatic runCycles(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         sampleCycle();
         applyStimulus(mode, 1'b0);
      end
   endtask

   task automatic latencyRead(input bit sel, input int ws);
      int n = 0, ce_cnt = 0;
      bit seen = 1'b0, overlap = 1'b0, den_seen = 1'b0;
      @(negedge Clk);
      lsel = sel;
      lreq = 1'b1;
      while (!seen && n < 40) begin
         @(negedge Clk);
         n++;
         if (sel ? (!l15_oe_n && !l15_we_n) : (!l1_oe_n && !l1_we_n)) overlap = 1'b1;
         if (sel ? !l15_ce_n : !l1_ce_n) ce_cnt++;
         if (sel ? l15_den : l1_den) den_seen = 1'b1;
         if (sel ? c15_if.ack : c1_if.ack) seen = 1'b1;
      end
      lreq = 1'b0;
      checkOutput(sel ? "lat15_ack_cycle" : "lat1_ack_cycle", 32'(n), 32'(ws + 2));
      checkOutput(sel ? "lat15_ce_cycles" : "lat1_ce_cycles", 32'(ce_cnt), 32'(ws + 1));
      checkOutput(sel ? "lat15_rdata" : "lat1_rdata", 32'(sel ? c15_if.rdata : c1_if.rdata), 32'h5A77);
      checkOutput(sel ? "lat15_overlap" : "lat1_overlap", 32'(overlap), 32'd0);
      checkOutput(sel ? "lat15_dout_en" : "lat1_dout_en", 32'(den_seen), 32'd0);
      checkOutput(sel ? "lat15_addr" : "lat1_addr", 32'(sel ? l15_addr : l1_addr), 32'h0077);
      checkOutput(sel ? "lat15_dout" : "lat1_dout", 32'(sel ? l15_dout : l1_dout), 32'h0000);
   endtask

   initial begin
      for (int p = 0; p < 2; p++) begin
         req_v[p] = 1'b0; we_v[p] = 1'b0; addr_v[p] = 16'h0000; wdata_v[p] = 16'h0000;
         exp_rdata[p] = 16'h0000; pending[p] = 1'b0; completed[p] = 1'b0;
      end
      for (int i = 0; i < 65536; i++) begin
         sram_mem[i] <= 16'(i * 7 + 3);
         ref_mem[i]   = 16'(i * 7 + 3);
      end
      sram_mem[16'h0042] <= 16'hBEEF;
      ref_mem[16'h0042]   = 16'hBEEF;

      $display("[TB] reset");
      for (int i = 0; i < 3; i++) begin
         sampleCycle();
         applyStimulus(0, 1'b1);
      end

      $display("[TB] directed CPU read 0x0042");
      sampleCycle();
      issueRequest(0, 1'b0, 16'h0042, 16'h0000);
      applyStimulus(0, 1'b0);
      runCycles(6, 0);
      checkOutput("read_0042", 32'(cpu_if.rdata), 32'hBEEF);

      $display("[TB] directed DBG write 0x1000");
      sampleCycle();
      issueRequest(1, 1'b1, 16'h1000, 16'h1234);
      applyStimulus(0, 1'b0);
      runCycles(6, 0);
      checkOutput("write_1000_mem", 32'(sram_mem[16'h1000]), 32'h1234);
      checkOutput("write_keeps_rdata", 32'(cpu_if.rdata), 32'hBEEF);

      $display("[TB] simultaneous requests");
      sampleCycle();
      issueRequest(0, 1'b0, 16'h1000, 16'h0000);
      issueRequest(1, 1'b0, 16'h0042, 16'h0000);
      applyStimulus(0, 1'b0);
      runCycles(12, 0);
      checkOutput("tie_cpu_rdata", 32'(cpu_if.rdata), 32'h1234);
      checkOutput("tie_dbg_rdata", 32'(dbg_if.rdata), 32'hBEEF);

      $display("[TB] both ports requesting continuously");
      runCycles(30, 2);
      runCycles(15, 0);

      $display("[TB] reset during write access");
      sampleCycle();
      issueRequest(1, 1'b1, 16'h0020, 16'hCAFE);
      applyStimulus(0, 1'b0);
      runCycles(2, 0);
      sampleCycle();
      applyStimulus(0, 1'b1);
      sampleCycle();
      checkOutput("abort_we_n", 32'(sram_we_n), 32'd1);
      applyStimulus(0, 1'b0);
      runCycles(8, 0);

      $display("[TB] random traffic");
      for (int i = 0; i < 2500; i++) begin
         sampleCycle();
         applyStimulus(1, ($urandom_range(0, 299) == 0));
      end
      runCycles(20, 0);

      $display("[TB] extreme wait states");
      latencyRead(1'b0, 1);
      latencyRead(1'b1, 15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
